// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the register-file write front end.
//   WB_ADDR_W / WB_DATA_W      register address and data widths
//   WB_FIFO_DEPTH_DEFAULT      default depth of the long-latency result FIFO
//   wb_entry_t                 one buffered write {rd, data}
package wb_pkg;

    localparam int unsigned WB_ADDR_W             = 5;
    localparam int unsigned WB_DATA_W             = 32;
    localparam int unsigned WB_FIFO_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t for long-latency results.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write push_entry (ignored when full)
//   push_entry   entry to write
//   pop          drop the head entry (ignored when empty)
//   head_c       current head entry (combinational read of storage)
//   full, empty  registered occupancy flags
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head_c,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_push) begin
            wr_ptr_nxt = (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_nxt = (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == CNT_W'(FIFO_DEPTH));
            empty  <= (count_nxt == '0);
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline writeback with buffered long-latency results onto
// the single register-file write port and tracks outstanding writes.
// Optional build macro WB_BYPASS_EN: a result arriving while the FIFO is empty
// and no pipeline write competes goes straight to the output register.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pipe_we, pipe_rd, pipe_data     pipeline WB write
//   mc_issue, mc_issue_rd           long-latency op issued from ID (sets busy)
//   mc_valid, mc_ready, mc_rd,
//   mc_data                         long-latency result handshake
//   busy                            outstanding-write scoreboard, bit 0 always 0
//   reg_write, wt_addr, wt_data     registered register-file write port
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_rd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic [31:0] busy,
    output logic        reg_write,
    output logic [4:0]  wt_addr,
    output logic [31:0] wt_data
);

    wb_entry_t   fifo_head_c;
    wb_entry_t   mc_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        pipe_sel;
    logic        byp_sel;
    logic        reg_write_nxt;
    logic [4:0]  wt_addr_nxt;
    logic [31:0] wt_data_nxt;
    logic [31:0] busy_nxt;

    assign mc_entry = '{rd: mc_rd, data: mc_data};
    assign mc_ready = !fifo_full;
    assign pipe_sel = pipe_we && (pipe_rd != '0);
    // The head is only consumed when the pipeline does not claim the port
    assign fifo_pop = !pipe_sel && !fifo_empty;

`ifdef WB_BYPASS_EN
    // Empty FIFO implies mc_ready, so this is a completed handshake
    assign byp_sel = fifo_empty && !pipe_sel && mc_valid;
`else
    assign byp_sel = 1'b0;
`endif

    assign fifo_push = mc_valid && mc_ready && !byp_sel;

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (mc_entry),
        .pop        (fifo_pop),
        .head_c     (fifo_head_c),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Write-port selection and scoreboard next-state
    always_comb begin
        reg_write_nxt = 1'b0;
        wt_addr_nxt   = wt_addr;
        wt_data_nxt   = wt_data;
        busy_nxt      = busy;
        if (pipe_sel) begin
            reg_write_nxt = 1'b1;
            wt_addr_nxt   = pipe_rd;
            wt_data_nxt   = pipe_data;
        end else if (fifo_pop) begin
            reg_write_nxt          = (fifo_head_c.rd != '0);
            wt_addr_nxt            = fifo_head_c.rd;
            wt_data_nxt            = fifo_head_c.data;
            busy_nxt[fifo_head_c.rd] = 1'b0;
        end else if (byp_sel) begin
            reg_write_nxt   = (mc_rd != '0);
            wt_addr_nxt     = mc_rd;
            wt_data_nxt     = mc_data;
            busy_nxt[mc_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue keeps the bit set
        if (mc_issue && (mc_issue_rd != '0)) begin
            busy_nxt[mc_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Output and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write <= 1'b0;
            wt_addr   <= '0;
            wt_data   <= '0;
            busy      <= '0;
        end else begin
            reg_write <= reg_write_nxt;
            wt_addr   <= wt_addr_nxt;
            wt_data   <= wt_data_nxt;
            busy      <= busy_nxt;
        end
    end

    // A pipeline write to a register still owed a long-latency result is illegal
    a_pipe_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(pipe_sel && busy[pipe_rd]))
        else $error("pipeline write to busy register x%0d", pipe_rd);

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter (FIFO_DEPTH = 2).
// Stimulus queues every expected register-file write; a negedge monitor pops
// and compares whenever reg_write is high. Cycle-exact checks sit in the
// stimulus thread, sampled 1 ns after the rising edge.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic [31:0] busy;
    logic        reg_write;
    logic [4:0]  wt_addr;
    logic [31:0] wt_data;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .busy        (busy),
        .reg_write   (reg_write),
        .wt_addr     (wt_addr),
        .wt_data     (wt_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every register-file write must match the next expected one
    always @(negedge clk) begin
        if (rst_n && reg_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         wt_addr, wt_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (wt_addr !== mon_e.a || wt_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL write_order: got addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                             wt_addr, wt_data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        pipe_we     = 1'b0;
        pipe_rd     = '0;
        pipe_data   = '0;
        mc_issue    = 1'b0;
        mc_issue_rd = '0;
        mc_valid    = 1'b0;
        mc_rd       = '0;
        mc_data     = '0;

        // Reset values
        #2;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_wt_addr",   32'(wt_addr),   32'd0);
        chk("rst_wt_data",   wt_data,        32'd0);
        chk("rst_busy",      busy,           32'd0);
        chk("rst_mc_ready",  32'(mc_ready),  32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("idle_reg_write", 32'(reg_write), 32'd0);

        // Pipeline write, then a dropped write to x0
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
        expect_wr(5'd5, 32'hDEAD_BEEF);
        step();
        chk("pipe_reg_write", 32'(reg_write), 32'd1);
        chk("pipe_wt_addr",   32'(wt_addr),   32'd5);
        chk("pipe_wt_data",   wt_data,        32'hDEAD_BEEF);
        pipe_rd = 5'd0; pipe_data = 32'h0BAD_0000;
        step();
        chk("pipe_x0_dropped", 32'(reg_write), 32'd0);
        pipe_we = 1'b0;

        // Issue x7, then its result with no pipeline traffic
        mc_issue = 1'b1; mc_issue_rd = 5'd7;
        step();
        mc_issue = 1'b0;
        chk("issue7_busy", busy, 32'h0000_0080);
        chk("issue7_ready", 32'(mc_ready), 32'd1);
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h0000_1234;
        expect_wr(5'd7, 32'h0000_1234);
        step();
        mc_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("res7_n1_reg_write", 32'(reg_write), 32'd1);
        chk("res7_n1_busy",      busy,           32'd0);
`else
        chk("res7_n1_reg_write", 32'(reg_write), 32'd0);
        chk("res7_n1_busy",      busy,           32'h0000_0080);
        step();
        chk("res7_n2_reg_write", 32'(reg_write), 32'd1);
        chk("res7_n2_busy",      busy,           32'd0);
`endif
        step();
        chk("res7_done", 32'(reg_write), 32'd0);

        // Pipeline starves the FIFO: back-pressure, then in-order drain
        for (int i = 10; i <= 12; i++) begin
            mc_issue = 1'b1; mc_issue_rd = 5'(i);
            step();
        end
        mc_issue = 1'b0;
        chk("starve_busy", busy, 32'h0000_1C00);
        pipe_we = 1'b1; pipe_rd = 5'd1;
        pipe_data = 32'h5000_0000; expect_wr(5'd1, 32'h5000_0000);
        mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'h0000_0A0A;
        step();
        chk("starve_ready1", 32'(mc_ready), 32'd1);
        pipe_data = 32'h5000_0001; expect_wr(5'd1, 32'h5000_0001);
        mc_rd = 5'd11; mc_data = 32'h0000_0B0B;
        step();
        chk("starve_ready2", 32'(mc_ready), 32'd0);
        pipe_data = 32'h5000_0002; expect_wr(5'd1, 32'h5000_0002);
        mc_rd = 5'd12; mc_data = 32'h0000_0C0C;
        step();
        chk("starve_ready3", 32'(mc_ready), 32'd0);
        pipe_data = 32'h5000_0003; expect_wr(5'd1, 32'h5000_0003);
        step();
        chk("starve_ready4", 32'(mc_ready), 32'd0);
        pipe_we = 1'b0;
        expect_wr(5'd10, 32'h0000_0A0A);
        expect_wr(5'd11, 32'h0000_0B0B);
        expect_wr(5'd12, 32'h0000_0C0C);
        step();
        chk("drain_a_addr",  32'(wt_addr),  32'd10);
        chk("drain_a_ready", 32'(mc_ready), 32'd1);
        step();
        mc_valid = 1'b0;
        chk("drain_b_addr",  32'(wt_addr),   32'd11);
        chk("drain_b_we",    32'(reg_write), 32'd1);
        step();
        chk("drain_c_addr",  32'(wt_addr),   32'd12);
        chk("drain_c_data",  wt_data,        32'h0000_0C0C);
        chk("drain_busy",    busy,           32'd0);
        step();
        chk("drain_done", 32'(reg_write), 32'd0);

        // Same-cycle issue of x9 while a result for x9 is written: set wins
        mc_issue = 1'b1; mc_issue_rd = 5'd9;
        step();
        mc_issue = 1'b0;
        chk("issue9_busy", busy, 32'h0000_0200);
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h0000_0099;
        expect_wr(5'd9, 32'h0000_0099);
`ifdef WB_BYPASS_EN
        mc_issue = 1'b1;
        step();
        mc_valid = 1'b0; mc_issue = 1'b0;
`else
        step();
        mc_valid = 1'b0; mc_issue = 1'b1;
        step();
        mc_issue = 1'b0;
`endif
        chk("setwins_we",   32'(reg_write), 32'd1);
        chk("setwins_addr", 32'(wt_addr),   32'd9);
        chk("setwins_busy", busy,           32'h0000_0200);
        step();
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h0000_009B;
        expect_wr(5'd9, 32'h0000_009B);
        step();
        mc_valid = 1'b0;
        step();
        step();
        chk("clear9_busy", busy, 32'd0);

        // Push while popping at occupancy 1
        pipe_we = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h2222_2222;
        expect_wr(5'd2, 32'h2222_2222);
        mc_valid = 1'b1; mc_rd = 5'd13; mc_data = 32'h0000_1313;
        step();
        pipe_we = 1'b0;
        mc_rd = 5'd14; mc_data = 32'h0000_1414;
        expect_wr(5'd13, 32'h0000_1313);
        expect_wr(5'd14, 32'h0000_1414);
        expect_wr(5'd15, 32'h0000_1515);
        step();
        chk("pp_x_addr", 32'(wt_addr), 32'd13);
        mc_rd = 5'd15; mc_data = 32'h0000_1515;
        step();
        mc_valid = 1'b0;
        chk("pp_y_addr",  32'(wt_addr),  32'd14);
        chk("pp_y_ready", 32'(mc_ready), 32'd1);
        step();
        chk("pp_z_addr", 32'(wt_addr),   32'd15);
        chk("pp_z_we",   32'(reg_write), 32'd1);
        step();
        chk("pp_no_dup", 32'(reg_write), 32'd0);

        // Result for x0 is accepted but never written
        mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h0000_0077;
        step();
        mc_valid = 1'b0;
        chk("x0_res_we1", 32'(reg_write), 32'd0);
        step();
        chk("x0_res_we2",   32'(reg_write), 32'd0);
        chk("x0_res_ready", 32'(mc_ready),  32'd1);
        step();

        // Asynchronous reset with two results buffered and x4/x5 busy
        mc_issue = 1'b1; mc_issue_rd = 5'd4;
        step();
        mc_issue_rd = 5'd5;
        step();
        mc_issue = 1'b0;
        pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h6000_0000;
        expect_wr(5'd1, 32'h6000_0000);
        mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h0000_0044;
        step();
        pipe_data = 32'h6000_0001; expect_wr(5'd1, 32'h6000_0001);
        mc_rd = 5'd5; mc_data = 32'h0000_0055;
        step();
        mc_valid = 1'b0;
        chk("prerst_busy",  busy,           32'h0000_0030);
        chk("prerst_ready", 32'(mc_ready),  32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_reg_write", 32'(reg_write), 32'd0);
        chk("arst_wt_addr",   32'(wt_addr),   32'd0);
        chk("arst_wt_data",   wt_data,        32'd0);
        chk("arst_busy",      busy,           32'd0);
        exp_q.delete();
        pipe_we = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("postrst_ready", 32'(mc_ready), 32'd1);
        step();
        step();
        chk("postrst_no_write", 32'(reg_write), 32'd0);
        chk("postrst_busy",     busy,           32'd0);
        step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
